// File: rtl/sw_pkg.sv
// sw_pkg: shared constants and types for the Smith-Waterman operand loader.
//   BASE_W / RES_W    : base and score widths
//   Q_LEN / R_LEN     : query and reference bases per job
//   BASE_A..BASE_T    : 2-bit base encodings
//   state_t           : loader FSM states
package sw_pkg;

    localparam int BASE_W = 2;
    localparam int RES_W  = 5;
    localparam int Q_LEN  = 6;
    localparam int R_LEN  = 10;

    localparam logic [BASE_W-1:0] BASE_A = 2'd0;
    localparam logic [BASE_W-1:0] BASE_C = 2'd1;
    localparam logic [BASE_W-1:0] BASE_G = 2'd2;
    localparam logic [BASE_W-1:0] BASE_T = 2'd3;

    typedef enum logic [1:0] {
        LOAD,
        RUN,
        OUT
    } state_t;

endpackage

// File: rtl/sw_timeout_ctr.sv
// sw_timeout_ctr: clear/enable cycle counter guarding the SW run phase.
//   clock, reset : rising-edge clock, synchronous active-low reset
//   clr          : force count to 0 (has priority over en)
//   en           : count one cycle
//   expired      : high during the TIMEOUT_CYC-th enabled cycle
module sw_timeout_ctr #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] count;

    // count holds the number of enabled cycles already completed, so the
    // flag is raised during the cycle that would make it TIMEOUT_CYC.
    assign expired = (count == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sw_seq_loader.sv
// sw_seq_loader: serial base loader and job sequencer for the SW core.
//   clock, reset           : rising-edge clock, synchronous active-low reset
//   in_valid/in_ready      : base beat handshake, in_base carries the base
//   sw_start               : level start to SW core, held for the whole run
//   sw_q, sw_r             : packed operands, base k at [BASE_W*k +: BASE_W]
//   sw_result, sw_done     : SW score and completion
//   out_valid/out_ready    : result handshake
//   out_result, out_error  : captured score (0 on timeout), timeout flag
module sw_seq_loader
    import sw_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BASE_W-1:0]         in_base,
    output logic                      sw_start,
    output logic [Q_LEN*BASE_W-1:0]   sw_q,
    output logic [R_LEN*BASE_W-1:0]   sw_r,
    input  logic [RES_W-1:0]          sw_result,
    input  logic                      sw_done,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [RES_W-1:0]          out_result,
    output logic                      out_error
);

    localparam int N_BEATS = Q_LEN + R_LEN;
    localparam int CNT_W   = $clog2(N_BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_BEATS - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] beat_cnt;
    logic             expired;
    logic             take;

    assign take = in_valid & in_ready;

    sw_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clr     (state != RUN),
        .en      (state == RUN),
        .expired (expired)
    );

    // State register
    always_ff @(posedge clock) begin
        if (!reset) state <= LOAD;
        else        state <= state_nxt;
    end

    // Next-state logic; sw_done outside RUN has no effect
    always_comb begin
        state_nxt = state;
        case (state)
            LOAD: if (take && beat_cnt == LAST_BEAT) state_nxt = RUN;
            RUN:  if (sw_done || expired)            state_nxt = OUT;
            OUT:  if (out_ready)                     state_nxt = LOAD;
            default:                                 state_nxt = LOAD;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        in_ready  = 1'b0;
        sw_start  = 1'b0;
        out_valid = 1'b0;
        case (state)
            LOAD:    in_ready  = 1'b1;
            RUN:     sw_start  = 1'b1;
            OUT:     out_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand slots are written in place by beat index (no shifting), so
    // the buses are stable for the SW core from the last beat onward.
    always_ff @(posedge clock) begin
        if (!reset) begin
            beat_cnt   <= '0;
            sw_q       <= '0;
            sw_r       <= '0;
            out_result <= '0;
            out_error  <= 1'b0;
        end else begin
            if (take) begin
                for (int k = 0; k < Q_LEN; k++)
                    if (beat_cnt == CNT_W'(k))
                        sw_q[BASE_W*k +: BASE_W] <= in_base;
                for (int k = 0; k < R_LEN; k++)
                    if (beat_cnt == CNT_W'(Q_LEN + k))
                        sw_r[BASE_W*k +: BASE_W] <= in_base;
                beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
            end
            // done beats a simultaneous timeout
            if (state == RUN) begin
                if (sw_done) begin
                    out_result <= sw_result;
                    out_error  <= 1'b0;
                end else if (expired) begin
                    out_result <= '0;
                    out_error  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sw_seq_loader.sv
module tb_sw_seq_loader;
    import sw_pkg::*;

    logic                    clock = 1'b0;
    logic                    reset;
    logic                    in_valid;
    logic                    in_ready;
    logic [BASE_W-1:0]       in_base;
    logic                    sw_start;
    logic [Q_LEN*BASE_W-1:0] sw_q;
    logic [R_LEN*BASE_W-1:0] sw_r;
    logic [RES_W-1:0]        sw_result;
    logic                    sw_done;
    logic                    out_valid;
    logic                    out_ready;
    logic [RES_W-1:0]        out_result;
    logic                    out_error;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    sw_seq_loader #(.TIMEOUT_CYC(255)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_base    (in_base),
        .sw_start   (sw_start),
        .sw_q       (sw_q),
        .sw_r       (sw_r),
        .sw_result  (sw_result),
        .sw_done    (sw_done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_error  (out_error)
    );

    typedef struct {
        string      name;
        int         b[16];     // 6 query bases then 10 reference bases
        bit         gaps;      // random in_valid gaps + spurious sw_done
        int         done_at;   // RUN cycle (1-based) with sw_done=1, 0 = never
        logic [4:0] res;       // score driven by the model SW
        int         stall;     // cycles out_ready held low
        logic [11:0] exp_q;
        logic [19:0] exp_r;
        logic [4:0]  exp_res;
        logic        exp_err;
    } job_t;

    job_t jobs[5];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input job_t j);
        logic bad;
        bad = 1'b0;
        check({j.name, "/ready_idle"}, in_ready, 1);
        for (int i = 0; i < 16; i++) begin
            if (j.gaps) begin
                int n;
                n = $urandom_range(0, 2);
                repeat (n) begin
                    in_valid = 1'b0;
                    in_base  = 2'($urandom);
                    sw_done  = 1'($urandom);
                    tick();
                    if (sw_start || out_valid || !in_ready) bad = 1'b1;
                end
            end
            in_valid = 1'b1;
            in_base  = 2'(j.b[i]);
            sw_done  = j.gaps ? 1'($urandom) : 1'b0;
            tick();
            if (i < 15 && (sw_start || out_valid || !in_ready)) bad = 1'b1;
        end
        in_valid = 1'b0;
        sw_done  = 1'b0;
        check({j.name, "/load_flags"}, bad, 0);
        check({j.name, "/start_after_last"}, sw_start, 1);
        check({j.name, "/ready_in_run"}, in_ready, 0);
        check({j.name, "/sw_q"}, sw_q, j.exp_q);
        check({j.name, "/sw_r"}, sw_r, j.exp_r);
    endtask

    task automatic run_job(input job_t j);
        int exp_c, c;
        logic bad;
        load(j);
        exp_c = (j.done_at >= 1 && j.done_at <= 255) ? j.done_at : 255;
        c = 0;
        for (int k = 1; k <= 300; k++) begin
            sw_done   = (k == j.done_at);
            sw_result = j.res;
            tick();
            sw_done = 1'b0;
            if (out_valid) begin
                c = k;
                break;
            end
        end
        check({j.name, "/run_cycles"}, c, exp_c);
        check({j.name, "/out_result"}, out_result, j.exp_res);
        check({j.name, "/out_error"}, out_error, j.exp_err);
        check({j.name, "/start_low_out"}, sw_start, 0);
        check({j.name, "/sw_q_held"}, sw_q, j.exp_q);
        bad = 1'b0;
        repeat (j.stall) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_base   = 2'($urandom);
            tick();
            if (!out_valid || in_ready || sw_start) bad = 1'b1;
        end
        in_valid = 1'b0;
        check({j.name, "/stall"}, bad, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({j.name, "/valid_drop"}, out_valid, 0);
        check({j.name, "/ready_after"}, in_ready, 1);
        check({j.name, "/result_hold"}, {out_error, out_result}, {j.exp_err, j.exp_res});
    endtask

    task automatic check_zero(input string nm);
        check({nm, "/sw_q"}, sw_q, 0);
        check({nm, "/sw_r"}, sw_r, 0);
        check({nm, "/flags"}, {sw_start, out_valid, out_error}, 0);
        check({nm, "/out_result"}, out_result, 0);
        check({nm, "/in_ready"}, in_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        jobs[0] = '{name: "basic", b: '{0,1,2,3,0,1, 0,3,2,0,1,2,3,1,3,0}, gaps: 0,
                    done_at: 20, res: 5'd7, stall: 10,
                    exp_q: 12'h4E4, exp_r: 20'h3792C, exp_res: 5'd7, exp_err: 1'b0};
        jobs[1] = '{name: "gaps", b: '{0,1,2,3,0,1, 0,3,2,0,1,2,3,1,3,0}, gaps: 1,
                    done_at: 5, res: 5'd31, stall: 0,
                    exp_q: 12'h4E4, exp_r: 20'h3792C, exp_res: 5'd31, exp_err: 1'b0};
        jobs[2] = '{name: "zero", b: '{0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0}, gaps: 0,
                    done_at: 1, res: 5'd0, stall: 2,
                    exp_q: 12'h000, exp_r: 20'h00000, exp_res: 5'd0, exp_err: 1'b0};
        jobs[3] = '{name: "timeout", b: '{3,3,3,3,3,3, 3,3,3,3,3,3,3,3,3,3}, gaps: 0,
                    done_at: 0, res: 5'd13, stall: 1,
                    exp_q: 12'hFFF, exp_r: 20'hFFFFF, exp_res: 5'd0, exp_err: 1'b1};
        jobs[4] = '{name: "done_at_limit", b: '{2,2,2,2,2,2, 1,1,1,1,1,1,1,1,1,1}, gaps: 0,
                    done_at: 255, res: 5'd9, stall: 0,
                    exp_q: 12'hAAA, exp_r: 20'h55555, exp_res: 5'd9, exp_err: 1'b0};

        reset = 1'b0; in_valid = 1'b0; in_base = '0;
        sw_result = '0; sw_done = 1'b0; out_ready = 1'b0;
        tick(); tick();
        reset = 1'b1;
        check_zero("reset");

        for (int t = 0; t < 5; t++) run_job(jobs[t]);

        // Reset during LOAD beat 9
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; in_base = 2'd1;
            tick();
        end
        in_valid = 1'b1; in_base = 2'd1; reset = 1'b0;
        tick();
        reset = 1'b1; in_valid = 1'b0;
        check_zero("rst_load");
        run_job(jobs[0]);

        // Reset during RUN
        load(jobs[4]);
        repeat (5) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_zero("rst_run");
        sw_done = 1'b1; sw_result = 5'd21;
        repeat (3) tick();
        sw_done = 1'b0;
        check("rst_run/no_result", {out_valid, in_ready, sw_start}, 3'b010);
        run_job(jobs[1]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sw_seq_loader.md
Name: sw_seq_loader

Overview:
- Upstream feeder for the Smith-Waterman scoring core (SW).
- Accepts a serial stream of 2-bit bases over a valid/ready handshake: Q_LEN query bases first, then R_LEN reference bases. Packs them into parallel operand buses.
- Runs one SW job via a start/done handshake with a timeout guard, then presents the score on a valid/ready result port.
- One job in flight at a time.

Parameters:
Q_LEN, 6, number of query bases per job
R_LEN, 10, number of reference bases per job
BASE_W, 2, bits per base
RES_W, 5, score width returned by SW
TIMEOUT_CYC, 255, max RUN cycles waiting for sw_done before abort (>=1)

Ports:
clock  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
in_valid  in  1  base beat valid
in_ready  out  1  loader can accept a base
in_base  in  BASE_W  base value
sw_start  out  1  start level to SW core
sw_q  out  Q_LEN*BASE_W  packed query; base k at bits [BASE_W*k +: BASE_W]
sw_r  out  R_LEN*BASE_W  packed reference; same packing
sw_result  in  RES_W  SW score, valid when sw_done=1
sw_done  in  1  SW completion
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_result  out  RES_W  captured score (0 on error)
out_error  out  1  job aborted by timeout; valid with out_valid

Behaviour:
- Reset (reset=0 at a rising edge):
  - state=LOAD, beat counter=0, timeout counter=0.
  - sw_q=0, sw_r=0, sw_start=0, out_valid=0, out_result=0, out_error=0.
  - in_ready=1 in the first cycle after reset is released.
  - Reset mid-job aborts immediately; no result is emitted.
- LOAD:
  - in_ready=1. A beat transfers when in_valid&in_ready.
  - Beats 0..Q_LEN-1 write sw_q slot = beat index. Beats Q_LEN..Q_LEN+R_LEN-1 write sw_r slot = beat index - Q_LEN.
  - Counter width is ceil(log2(Q_LEN+R_LEN)).
  - Transfer of beat Q_LEN+R_LEN-1 -> RUN next cycle, counter cleared.
  - sw_done in LOAD is ignored.
- RUN:
  - in_ready=0, sw_start=1 (level, held), sw_q/sw_r held stable.
  - Timeout counter increments each RUN cycle.
  - sw_done=1: capture sw_result into out_result, out_error=0, -> OUT.
  - Otherwise, timeout counter reaching TIMEOUT_CYC: out_result=0, out_error=1, -> OUT.
  - sw_done and timeout in the same cycle: done wins.
  - sw_start first asserts the cycle after the last beat transfers, and deasserts on entry to OUT.
- OUT:
  - out_valid=1, in_ready=0, sw_start=0.
  - out_valid&out_ready -> LOAD next cycle: out_valid=0, timeout counter=0.
  - out_result/out_error hold until the next job's capture. sw_q/sw_r hold until overwritten.
  - out_ready low stalls indefinitely; no new beats are accepted (no overlap).
- Minimum job latency: Q_LEN+R_LEN beat cycles + SW run + 1 cycle to out_valid.
- in_base is ignored when the beat does not transfer.

Decomposition:
- Package sw_pkg:
  - BASE_W, RES_W, Q_LEN, R_LEN.
  - Base encoding constants A=0, C=1, G=2, T=3.
  - State enum {LOAD, RUN, OUT}.
- Sub-module sw_timeout_ctr:
  - Clear/enable counter with an expired flag at TIMEOUT_CYC.
  - Same clock and active-low synchronous reset.
- Remainder is a single FSM plus shift-free indexed operand registers.

Test Plan:
- Basic load: stream query 0,1,2,3,0,1 then ref 0,3,2,0,1,2,3,1,3,0 with in_valid held high -> sw_q=12'h4E4, sw_r=20'h3792C, sw_start rises the cycle after beat 16.
- Completion: model SW returns sw_done=1 with sw_result=5'd7 after 20 RUN cycles -> out_valid=1 the next cycle, out_result=7, out_error=0, sw_start=0.
- Backpressure both sides:
  - Input: random in_valid gaps give the same packed buses as the basic-load scenario.
  - Output: out_ready held 0 for 10 cycles -> out_valid stays 1, in_ready=0.
  - Result then accepted on out_ready=1, and in_ready=1 the cycle after.
- Timeout: sw_done never asserted -> after TIMEOUT_CYC=255 RUN cycles out_valid=1, out_error=1, out_result=0. With sw_done on exactly cycle 255, out_error=0.
- Reset mid-operation: reset=0 during beat 9 of LOAD, and separately during RUN -> the next cycle shows all outputs 0 and in_ready=1. A fresh 16-beat job then completes normally.
- Spurious done: sw_done=1 during LOAD -> ignored, no out_valid, beat counter unaffected.
